// File: rtl/main_memory_burst_pkg.sv
// Shared definitions for the burst main memory: op encodings, FSM states,
// default geometry and the per-op latency rule.
package mem_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_BLOCK_WORDS = 4;

  typedef enum logic [1:0] {
    OP_WR_WORD = 2'b00,
    OP_RD_LINE = 2'b01,
    OP_WB_LINE = 2'b10,
    OP_ILLEGAL = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT
  } mem_state_e;

  // Illegal ops still take one cycle so Done/Err keep the normal pulse timing.
  function automatic int unsigned op_latency(input mem_op_e op,
                                             input int unsigned rd_lat,
                                             input int unsigned wr_lat);
    case (op)
      OP_RD_LINE:             return rd_lat;
      OP_WR_WORD, OP_WB_LINE: return wr_lat;
      default:                return 1;
    endcase
  endfunction

endpackage

// File: rtl/main_memory_burst_if.sv
// Request/response bundle between a requester (master) and the burst memory (slave).
interface main_memory_burst_if #(
  parameter int unsigned DATA_WIDTH  = mem_pkg::DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned BLOCK_WORDS = mem_pkg::DEF_BLOCK_WORDS
);

  logic                              Req_Valid;
  logic                              Req_Ready;
  logic [1:0]                        Req_Op;
  logic [ADDR_WIDTH-1:0]             Address;
  logic [DATA_WIDTH-1:0]             Data_in;
  logic [BLOCK_WORDS*DATA_WIDTH-1:0] Line_in;
  logic [BLOCK_WORDS*DATA_WIDTH-1:0] Line_out;
  logic                              Done;
  logic                              Err;
  logic                              Busy;

  modport master (
    output Req_Valid, Req_Op, Address, Data_in, Line_in,
    input  Req_Ready, Line_out, Done, Err, Busy
  );

  modport slave (
    input  Req_Valid, Req_Op, Address, Data_in, Line_in,
    output Req_Ready, Line_out, Done, Err, Busy
  );

endinterface

// File: rtl/mem_latency_counter.sv
// Loadable down-counter with a zero flag; holds at zero once reached.
module mem_latency_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/main_memory_burst.sv
// Word-addressable main memory with word write, line read and line write-back,
// fixed per-op latencies, and a post-reset zero-fill of the whole array.
module main_memory_burst
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int unsigned RD_LATENCY  = 2,
  parameter int unsigned WR_LATENCY  = 4,
  parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH),
  parameter int unsigned OFF_WIDTH   = $clog2(BLOCK_WORDS)
) (
  input  logic                CLK,
  input  logic                rst_n,
  main_memory_burst_if.slave  bus
);

  localparam int unsigned LINES   = DEPTH / BLOCK_WORDS;
  localparam int unsigned LINE_W  = ADDR_WIDTH - OFF_WIDTH;
  localparam int unsigned LW      = BLOCK_WORDS * DATA_WIDTH;
  localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  mem_state_e            state_q, state_d;
  logic [LINE_W-1:0]     fill_ptr_q, fill_ptr_d;
  mem_op_e               op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [LW-1:0]         line_q;
  logic [LW-1:0]         line_out_q;
  logic                  done_q;
  logic                  err_q;

  logic                  ready;
  logic                  busy;
  logic                  accept;
  logic                  fill_we;
  logic                  exec;
  logic                  cnt_dec;
  logic                  cnt_zero;
  logic [CNT_W-1:0]      cnt_load_val;

  always_comb begin
    state_d    = state_q;
    fill_ptr_d = fill_ptr_q;
    fill_we    = 1'b0;
    accept     = 1'b0;
    exec       = 1'b0;
    cnt_dec    = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_INIT: begin
        busy       = 1'b1;
        fill_we    = 1'b1;
        fill_ptr_d = fill_ptr_q + LINE_W'(1);
        if (fill_ptr_q == LINE_W'(LINES - 1)) begin
          fill_ptr_d = '0;
          state_d    = ST_IDLE;
        end
      end
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.Req_Valid) begin
          accept  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (cnt_zero) begin
          exec    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Counter is loaded with LAT-1 so execution lands exactly LAT edges after accept.
  assign cnt_load_val = CNT_W'(op_latency(mem_op_e'(bus.Req_Op), RD_LATENCY, WR_LATENCY) - 1);

  mem_latency_counter #(
    .WIDTH (CNT_W)
  ) u_lat_cnt (
    .clk        (CLK),
    .rst_n      (rst_n),
    .load_i     (accept),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      fill_ptr_q <= '0;
      op_q       <= OP_WR_WORD;
      addr_q     <= '0;
      data_q     <= '0;
      line_q     <= '0;
      line_out_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_ptr_q <= fill_ptr_d;
      done_q     <= exec;
      err_q      <= exec && (op_q == OP_ILLEGAL);
      if (accept) begin
        op_q   <= mem_op_e'(bus.Req_Op);
        addr_q <= bus.Address;
        data_q <= bus.Data_in;
        line_q <= bus.Line_in;
      end
      if (exec && (op_q == OP_RD_LINE)) begin
        for (int unsigned k = 0; k < BLOCK_WORDS; k++) begin
          line_out_q[k*DATA_WIDTH +: DATA_WIDTH] <=
            mem[{addr_q[ADDR_WIDTH-1:OFF_WIDTH], OFF_WIDTH'(k)}];
        end
      end
    end
  end

  // Array has no reset; it is cleared by the INIT sweep instead.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      for (int unsigned k = 0; k < BLOCK_WORDS; k++) begin
        mem[{fill_ptr_q, OFF_WIDTH'(k)}] <= '0;
      end
    end else if (exec) begin
      case (op_q)
        OP_WR_WORD: mem[addr_q] <= data_q;
        OP_WB_LINE: begin
          for (int unsigned k = 0; k < BLOCK_WORDS; k++) begin
            mem[{addr_q[ADDR_WIDTH-1:OFF_WIDTH], OFF_WIDTH'(k)}] <=
              line_q[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Req_Ready = ready;
  assign bus.Busy      = busy;
  assign bus.Line_out  = line_out_q;
  assign bus.Done      = done_q;
  assign bus.Err       = err_q;

endmodule

// File: tb/tb_main_memory_burst.sv
// Randomised self-checking bench for main_memory_burst against an array-level model.
module tb_main_memory_burst;

  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int BW    = 4;
  localparam int RDL   = 2;
  localparam int WRL   = 4;
  localparam int AW    = 10;
  localparam int LW    = BW * DW;
  localparam int LINES = DEPTH / BW;
  localparam int TCK   = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #(TCK/2) clk = ~clk;

  main_memory_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) bus ();

  main_memory_burst #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .BLOCK_WORDS (BW),
    .RD_LATENCY  (RDL),
    .WR_LATENCY  (WRL)
  ) dut (
    .CLK   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl [DEPTH];
  logic [LW-1:0] mdl_line;
  longint        t_acc;

  task automatic check_eq(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] op);
    if (op == 2'b01) return RDL;
    if (op == 2'b11) return 1;
    return WRL;
  endfunction

  function automatic logic [LW-1:0] model_line(input int a);
    logic [LW-1:0] r;
    int base;
    base = a - (a % BW);
    for (int k = 0; k < BW; k++) r[k*DW +: DW] = mdl[base + k];
    return r;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < BW; k++) r[k*DW +: DW] = $urandom;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    mdl_line = '0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!bus.Req_Ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!bus.Req_Ready) check_eq("ready_timeout", 0, 1);
  endtask

  // Issues one request starting from a negedge; returns at the negedge where Done is seen.
  task automatic do_req(input logic [1:0] op, input int addr, input logic [DW-1:0] data,
                        input logic [LW-1:0] line, input bit hold);
    int cyc;
    bit got;
    wait_ready(40);
    bus.Req_Valid = 1'b1;
    bus.Req_Op    = op;
    bus.Address   = AW'(addr);
    bus.Data_in   = data;
    bus.Line_in   = line;
    @(posedge clk);
    t_acc = $time;
    #1;
    if (!hold) begin
      bus.Req_Valid = 1'b0;
      bus.Req_Op    = 2'($urandom);
      bus.Address   = AW'($urandom);
      bus.Data_in   = $urandom;
      bus.Line_in   = rand_line();
    end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.Done) begin
        got = 1'b1;
      end else begin
        check_eq("ready_low", bus.Req_Ready, 0);
        check_eq("busy_wait", bus.Busy, 1);
        check_eq("lineout_hold", bus.Line_out, mdl_line);
      end
    end
    check_eq("done_cycle", cyc, lat_of(op) + 1);
    check_eq("err_flag", bus.Err, (op == 2'b11) ? 1 : 0);
    case (op)
      2'b00: mdl[addr] = data;
      2'b01: mdl_line = model_line(addr);
      2'b10: for (int k = 0; k < BW; k++) mdl[addr - (addr % BW) + k] = line[k*DW +: DW];
      default: ;
    endcase
    check_eq("line_out", bus.Line_out, mdl_line);
    check_eq("ready_on_done", bus.Req_Ready, 1);
  endtask

  task automatic init_count();
    int n = 0;
    while (!bus.Req_Ready && n < 1000) begin
      @(negedge clk);
      n++;
      if (!bus.Req_Ready) check_eq("busy_init", bus.Busy, 1);
    end
    check_eq("init_cycles", n, LINES);
    check_eq("busy_idle", bus.Busy, 0);
  endtask

  initial begin
    logic [LW-1:0] exp_line;
    logic [LW-1:0] wl;
    longint        t_prev;
    bit            any_done;

    rst_n         = 1'b0;
    bus.Req_Valid = 1'b0;
    bus.Req_Op    = '0;
    bus.Address   = '0;
    bus.Data_in   = '0;
    bus.Line_in   = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_eq("rst_ready", bus.Req_Ready, 0);
    check_eq("rst_busy", bus.Busy, 1);
    check_eq("rst_done", bus.Done, 0);
    check_eq("rst_err", bus.Err, 0);
    check_eq("rst_lineout", bus.Line_out, 0);

    // Requests presented during INIT must be ignored.
    bus.Req_Valid = 1'b1;
    bus.Req_Op    = 2'b00;
    bus.Address   = AW'(3);
    bus.Data_in   = 32'h1234_5678;
    rst_n = 1'b1;
    @(negedge clk);
    bus.Req_Valid = 1'b0;
    begin
      int n = 1;
      while (!bus.Req_Ready && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check_eq("init_cycles", n, LINES);
      check_eq("busy_idle", bus.Busy, 0);
    end

    do_req(2'b01, 'h3FC, '0, '0, 1'b0);
    check_eq("zero_line_3fc", bus.Line_out, 0);
    do_req(2'b01, 'h000, '0, '0, 1'b0);
    check_eq("init_ignored_req", bus.Line_out, 0);

    do_req(2'b00, 'h005, 32'hDEAD_BEEF, '0, 1'b0);
    do_req(2'b01, 'h006, '0, '0, 1'b0);
    exp_line = '0;
    exp_line[1*DW +: DW] = 32'hDEAD_BEEF;
    check_eq("word_write_read", bus.Line_out, exp_line);

    wl = '0;
    wl[0*DW +: DW] = 32'h11;
    wl[1*DW +: DW] = 32'h22;
    wl[2*DW +: DW] = 32'h33;
    wl[3*DW +: DW] = 32'h44;
    do_req(2'b10, 'h010, '0, wl, 1'b0);
    do_req(2'b01, 'h013, '0, '0, 1'b0);
    check_eq("wb_read", bus.Line_out, wl);

    do_req(2'b00, 'h001, 32'hA5A5_0001, '0, 1'b0);
    do_req(2'b11, 'h000, 32'hFFFF_FFFF, rand_line(), 1'b0);
    @(negedge clk);
    check_eq("done_one_cycle", bus.Done, 0);
    check_eq("err_one_cycle", bus.Err, 0);
    do_req(2'b01, 'h000, '0, '0, 1'b0);

    // A word write into a line must not disturb the held read line.
    do_req(2'b00, 'h002, 32'h0BAD_F00D, '0, 1'b0);
    check_eq("wr_no_lineout", bus.Line_out, model_line('h000) & ~{{(LW-3*DW){1'b0}}, 32'hFFFF_FFFF, {(2*DW){1'b0}}});

    for (int i = 0; i < 60; i++) begin
      int a;
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      a  = (i % 3 == 0) ? (($urandom_range(0, 7)) + 'h40) : $urandom_range(0, DEPTH - 1);
      do_req(op, a, $urandom, rand_line(), 1'b0);
    end

    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      do_req(2'b01, $urandom_range(0, DEPTH - 1), '0, '0, 1'b1);
      if (i > 0) check_eq("b2b_interval", t_acc - t_prev, (RDL + 1) * TCK);
      t_prev = t_acc;
    end
    bus.Req_Valid = 1'b0;

    do_req(2'b01, 'h040, '0, '0, 1'b0);

    wait_ready(40);
    bus.Req_Valid = 1'b1;
    bus.Req_Op    = 2'b00;
    bus.Address   = AW'('h020);
    bus.Data_in   = 32'hCAFE_0020;
    @(posedge clk);
    #1 bus.Req_Valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_ready", bus.Req_Ready, 0);
    check_eq("midrst_busy", bus.Busy, 1);
    check_eq("midrst_lineout", bus.Line_out, 0);
    any_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.Done) any_done = 1'b1;
    end
    check_eq("midrst_no_done", any_done, 0);
    model_clear();
    rst_n = 1'b1;
    init_count();
    do_req(2'b01, 'h020, '0, '0, 1'b0);
    check_eq("midrst_read_zero", bus.Line_out, 0);
    do_req(2'b01, 'h013, '0, '0, 1'b0);
    check_eq("reinit_wb_cleared", bus.Line_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
